// File: rtl/cavlc_pkg.sv
// Shared CAVLC control definitions: sequencer state encoding and the
// shift-request bundle each residual decoder presents to the shifter arbiter.
package cavlc_pkg;

    // Default shift bus width of the residual decoders.
    localparam int SHIFT_W_DEF = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_BS = 3'd1,
        CT0     = 3'd2,
        CT1     = 3'd3,
        LEVEL   = 3'd4,
        ZERO    = 3'd5,
        ERR     = 3'd6
    } cavlcState_t;

    typedef struct packed {
        logic                   en;
        logic [SHIFT_W_DEF-1:0] num;
    } shiftReq_t;

endpackage

// File: rtl/cavlc_watchdog.sv
// Loadable down-counter that flags a decoder which never reports done.
// clear reloads TIMEOUT-1; while enabled it counts to zero and holds there.
module cavlc_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic Clk,
    input  logic nReset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Reload on clear, otherwise count down while the guarded state is active.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)
            cnt <= LOAD;
        else if (clear)
            cnt <= LOAD;
        else if (enable && (cnt != '0))
            cnt <= cnt - CNT_W'(1);
    end

    // Expiry lands in the TIMEOUT-th cycle of the guarded state.
    assign expired = enable && (cnt == '0);

endmodule

// File: rtl/cavlc_ctrl_seq.sv
// CAVLC residual block sequencer: walks each block through coefficient-token,
// level and run-before decode, counts blocks per macroblock, arbitrates the
// barrel shifter and traps stalled decoders into a sticky error state.
module cavlc_ctrl_seq
    import cavlc_pkg::*;
#(
    parameter int SHIFT_W       = 5,
    parameter int BLOCKS_PER_MB = 16,
    parameter int TIMEOUT       = 1023,
    localparam int IDX_W        = (BLOCKS_PER_MB > 1) ? $clog2(BLOCKS_PER_MB) : 1
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               Enable,
    input  logic               Abort,
    input  logic               BarrelShifterReady,
    input  logic [4:0]         TotalCoeff,
    input  logic [SHIFT_W-1:0] NumShift_CoeffToken,
    input  logic [SHIFT_W-1:0] NumShift_Level,
    input  logic               ShiftEn_Level,
    input  logic [SHIFT_W-1:0] NumShift_Zero,
    input  logic               ShiftEn_Zero,
    input  logic               LevelDecodeDone,
    input  logic               ZeroDecodeDone,
    output logic               ShiftEn,
    output logic [SHIFT_W-1:0] NumShift,
    output logic               CoeffTokenDecodeEnable,
    output logic               LevelDecodeEnable,
    output logic               ZeroDecodeEnable,
    output logic               BarrelShiftEn,
    output logic               BlockDone,
    output logic               MbDone,
    output logic [IDX_W-1:0]   BlockIdx,
    output logic               Error
);
    // Same shape as the package shift request, sized to this instance's bus.
    typedef struct packed {
        logic               en;
        logic [SHIFT_W-1:0] num;
    } shiftSel_t;

    cavlcState_t state, stateNext;
    shiftSel_t   sel;
    logic        wdExpired, wdClear, wdEn;
    logic        blkEvent, lastBlk;

    assign wdEn    = (state == LEVEL) || (state == ZERO);
    assign wdClear = Abort || (stateNext != state);
    assign lastBlk = (BlockIdx == IDX_W'(BLOCKS_PER_MB - 1));

    // An aborted cycle never completes a block.
    assign blkEvent = !Abort &&
                      (((state == CT1) && (TotalCoeff == 5'd0)) ||
                       ((state == ZERO) && ZeroDecodeDone));

    cavlc_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
        .Clk     (Clk),
        .nReset  (nReset),
        .clear   (wdClear),
        .enable  (wdEn),
        .expired (wdExpired)
    );

    // Next state; a decoder's done wins over a coincident timeout, Abort wins over all.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (Enable) stateNext = WAIT_BS;
            WAIT_BS: if (BarrelShifterReady) stateNext = CT0;
            CT0:     stateNext = CT1;
            CT1:     if (TotalCoeff == 5'd0) stateNext = Enable ? CT0 : IDLE;
                     else                    stateNext = LEVEL;
            LEVEL:   if (LevelDecodeDone)    stateNext = ZERO;
                     else if (wdExpired)     stateNext = ERR;
            ZERO:    if (ZeroDecodeDone)     stateNext = Enable ? CT0 : IDLE;
                     else if (wdExpired)     stateNext = ERR;
            ERR:     stateNext = ERR;
            default: stateNext = IDLE;
        endcase
        if (Abort) stateNext = IDLE;
    end

    // Shifter arbitration follows the current state only.
    always_comb begin
        sel = '0;
        case (state)
            CT1:     begin sel.en = 1'b1;          sel.num = NumShift_CoeffToken; end
            LEVEL:   begin sel.en = ShiftEn_Level; sel.num = NumShift_Level;      end
            ZERO:    begin sel.en = ShiftEn_Zero;  sel.num = NumShift_Zero;       end
            default: sel = '0;
        endcase
    end

    assign ShiftEn  = sel.en;
    assign NumShift = sel.num;

    // State register and state-derived enables, each one cycle behind its state.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state                  <= IDLE;
            CoeffTokenDecodeEnable <= 1'b0;
            LevelDecodeEnable      <= 1'b0;
            ZeroDecodeEnable       <= 1'b0;
            BarrelShiftEn          <= 1'b0;
        end else begin
            state                  <= stateNext;
            CoeffTokenDecodeEnable <= (state == CT0);
            LevelDecodeEnable      <= (state == LEVEL);
            ZeroDecodeEnable       <= (state == ZERO);
            BarrelShiftEn          <= (state != IDLE) && (state != ERR);
        end
    end

    // Block/macroblock bookkeeping and the sticky error flag.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            BlockDone <= 1'b0;
            MbDone    <= 1'b0;
            BlockIdx  <= '0;
            Error     <= 1'b0;
        end else begin
            BlockDone <= blkEvent;
            MbDone    <= blkEvent && lastBlk;
            if (Abort)
                BlockIdx <= '0;
            else if (blkEvent)
                BlockIdx <= lastBlk ? '0 : BlockIdx + IDX_W'(1);
            if (Abort)
                Error <= 1'b0;
            else if (stateNext == ERR)
                Error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cavlc_ctrl_seq.sv
// Directed bench for cavlc_ctrl_seq with 4 blocks per macroblock and an
// 8-cycle watchdog; expected values are worked out by hand per cycle.
module tb_cavlc_ctrl_seq;
    logic       Clk = 1'b0;
    logic       nReset, Enable, Abort, BarrelShifterReady;
    logic [4:0] TotalCoeff;
    logic [4:0] NumShift_CoeffToken, NumShift_Level, NumShift_Zero;
    logic       ShiftEn_Level, ShiftEn_Zero, LevelDecodeDone, ZeroDecodeDone;
    logic       ShiftEn, CoeffTokenDecodeEnable, LevelDecodeEnable, ZeroDecodeEnable;
    logic       BarrelShiftEn, BlockDone, MbDone, Error;
    logic [4:0] NumShift;
    logic [1:0] BlockIdx;

    int total = 0;
    int bad   = 0;
    int ctCnt = 0, lvCnt = 0, zrCnt = 0;
    int ct0, lv0, zr0;

    always #5 Clk = ~Clk;

    cavlc_ctrl_seq #(.SHIFT_W(5), .BLOCKS_PER_MB(4), .TIMEOUT(8)) dut (
        .Clk(Clk), .nReset(nReset), .Enable(Enable), .Abort(Abort),
        .BarrelShifterReady(BarrelShifterReady), .TotalCoeff(TotalCoeff),
        .NumShift_CoeffToken(NumShift_CoeffToken), .NumShift_Level(NumShift_Level),
        .ShiftEn_Level(ShiftEn_Level), .NumShift_Zero(NumShift_Zero),
        .ShiftEn_Zero(ShiftEn_Zero), .LevelDecodeDone(LevelDecodeDone),
        .ZeroDecodeDone(ZeroDecodeDone), .ShiftEn(ShiftEn), .NumShift(NumShift),
        .CoeffTokenDecodeEnable(CoeffTokenDecodeEnable),
        .LevelDecodeEnable(LevelDecodeEnable), .ZeroDecodeEnable(ZeroDecodeEnable),
        .BarrelShiftEn(BarrelShiftEn), .BlockDone(BlockDone), .MbDone(MbDone),
        .BlockIdx(BlockIdx), .Error(Error)
    );

    // Count high cycles of each decoder enable, sampled mid-cycle.
    always @(negedge Clk) begin
        if (CoeffTokenDecodeEnable) ctCnt++;
        if (LevelDecodeEnable)      lvCnt++;
        if (ZeroDecodeEnable)       zrCnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        nReset = 1'b0; Enable = 1'b0; Abort = 1'b0; BarrelShifterReady = 1'b0;
        TotalCoeff = '0; NumShift_CoeffToken = '0; NumShift_Level = '0; NumShift_Zero = '0;
        ShiftEn_Level = 1'b0; ShiftEn_Zero = 1'b0; LevelDecodeDone = 1'b0; ZeroDecodeDone = 1'b0;
        tick(); tick();
        chk("rst_enables", {CoeffTokenDecodeEnable, LevelDecodeEnable, ZeroDecodeEnable, BarrelShiftEn}, 0);
        chk("rst_pulses", {BlockDone, MbDone, Error}, 0);
        chk("rst_idx", BlockIdx, 0);
        chk("rst_shift", {ShiftEn, NumShift}, 0);
        nReset = 1'b1;
        tick();

        // Full block: TotalCoeff=3, each done two cycles into its state.
        Enable = 1'b1; BarrelShifterReady = 1'b1; TotalCoeff = 5'd3; NumShift_CoeffToken = 5'd9;
        ct0 = ctCnt;
        tick();                                    // WAIT_BS
        tick();                                    // CT0
        chk("t1_bsen", BarrelShiftEn, 1);
        tick();                                    // CT1
        chk("t1_ct_shen", ShiftEn, 1);
        chk("t1_ct_num", NumShift, 9);
        chk("t1_cten", CoeffTokenDecodeEnable, 1);
        tick();                                    // LEVEL entered
        chk("t1_lven_lag", LevelDecodeEnable, 0);
        ShiftEn_Level = 1'b1; NumShift_Level = 5'd7;
        #1;
        chk("t1_lv_shen", ShiftEn, 1);
        chk("t1_lv_num", NumShift, 7);
        tick();                                    // LEVEL, second cycle
        chk("t1_lven", LevelDecodeEnable, 1);
        LevelDecodeDone = 1'b1;
        tick();                                    // ZERO entered
        LevelDecodeDone = 1'b0; ShiftEn_Level = 1'b0; NumShift_Level = '0;
        ShiftEn_Zero = 1'b1; NumShift_Zero = 5'd3;
        #1;
        chk("t1_zr_shift", {ShiftEn, NumShift}, {1'b1, 5'd3});
        chk("t1_bd_early", BlockDone, 0);
        tick();                                    // ZERO, second cycle
        chk("t1_zren", ZeroDecodeEnable, 1);
        ZeroDecodeDone = 1'b1; Enable = 1'b0;
        tick();                                    // IDLE, pulse out
        ZeroDecodeDone = 1'b0; ShiftEn_Zero = 1'b0; NumShift_Zero = '0;
        chk("t1_bd", BlockDone, 1);
        chk("t1_idx", BlockIdx, 1);
        chk("t1_mb", MbDone, 0);
        tick();
        chk("t1_bd_one", BlockDone, 0);
        chk("t1_ctcnt", ctCnt - ct0, 1);

        // Abort in IDLE clears the block index.
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("abort_idx", BlockIdx, 0);

        // Four back-to-back empty blocks close the macroblock.
        lv0 = lvCnt; zr0 = zrCnt;
        Enable = 1'b1; TotalCoeff = 5'd0;
        tick(); tick(); tick();                    // WAIT_BS, CT0, CT1
        chk("t2_bd_ct1", BlockDone, 0);
        for (int b = 0; b < 4; b++) begin
            tick();                                // CT0 (or IDLE after the last)
            chk("t2_bd", BlockDone, 1);
            chk("t2_idx", BlockIdx, (b + 1) % 4);
            chk("t2_mb", MbDone, (b == 3));
            if (b < 3) begin
                tick();                            // CT1 of the next block
                chk("t2_bd_gap", BlockDone, 0);
                chk("t2_cten", CoeffTokenDecodeEnable, 1);
                if (b == 2) Enable = 1'b0;
            end
        end
        tick();
        chk("t2_mb_one", MbDone, 0);
        chk("t2_bsen_idle", BarrelShiftEn, 0);
        chk("t2_no_lvzr", {lvCnt - lv0, zrCnt - zr0}, 0);

        // Stalled level decoder trips the watchdog.
        Enable = 1'b1; TotalCoeff = 5'd5;
        tick(); tick(); tick(); tick();            // WAIT_BS, CT0, CT1, LEVEL
        chk("t4_err_entry", Error, 0);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("t4_err_early", Error, 0);
        end
        tick();                                    // 8 cycles after LEVEL entry
        chk("t4_err", Error, 1);
        chk("t4_bsen_last", BarrelShiftEn, 1);
        tick();
        chk("t4_bsen_drop", BarrelShiftEn, 0);
        chk("t4_err_hold", Error, 1);
        ShiftEn_Level = 1'b1; NumShift_Level = 5'd7;
        #1;
        chk("t4_err_shift", {ShiftEn, NumShift}, 0);
        ShiftEn_Level = 1'b0; NumShift_Level = '0;
        Enable = 1'b0; Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("t4_err_clr", Error, 0);
        tick();
        chk("t4_idle_bsen", BarrelShiftEn, 0);

        // Abort coincident with ZeroDecodeDone suppresses completion.
        Enable = 1'b1; TotalCoeff = 5'd2;
        tick(); tick(); tick(); tick();            // WAIT_BS, CT0, CT1, LEVEL
        LevelDecodeDone = 1'b1;
        tick();                                    // ZERO
        LevelDecodeDone = 1'b0;
        ZeroDecodeDone = 1'b1; Abort = 1'b1; Enable = 1'b0;
        tick();                                    // IDLE
        ZeroDecodeDone = 1'b0; Abort = 1'b0;
        chk("t5_bd", BlockDone, 0);
        chk("t5_idx", BlockIdx, 0);
        tick();
        chk("t5_bd_after", BlockDone, 0);
        chk("t5_bsen", BarrelShiftEn, 0);
        ShiftEn_Level = 1'b1; NumShift_Level = 5'd7;
        #1;
        chk("idle_shen", ShiftEn, 0);
        chk("idle_num", NumShift, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cavlc_ctrl_seq.md
# cavlc_ctrl_seq

Parametrised control sequencer for the CAVLC residual decoder. It drives one block at a time through coefficient-token, level and run-before (zero) decode, and arbitrates which decoder steers the barrel shifter. Compared with the fixed single-block controller, it adds three things: configurable shift width, a per-macroblock block counter with a macroblock-done pulse, and an early skip of level/zero decode when TotalCoeff is 0. It also adds a stall watchdog with an error state and a synchronous abort. It sits between the external slice controller and the CoeffToken/Level/Zero decoders plus the barrel shifter.

## Interface
Parameters:
- SHIFT_W, 5: width of every NumShift bus.
- BLOCKS_PER_MB, 16: blocks per macroblock (range 1..32).
- TIMEOUT, 1023: maximum cycles allowed in LEVEL or ZERO without the matching done (range ≥2).

Ports:
- Clk  in  1  clock.
- nReset  in  1  reset, asynchronous, active-low.
- Enable  in  1  run request from the external controller.
- Abort  in  1  synchronous abort; highest priority.
- BarrelShifterReady  in  1  shifter holds valid bits.
- TotalCoeff  in  5  from CoeffTokenDecode; valid in CT1.
- NumShift_CoeffToken  in  SHIFT_W  shift amount in CT1.
- NumShift_Level  in  SHIFT_W  shift amount from LevelDecode.
- ShiftEn_Level  in  1  shift request from LevelDecode.
- NumShift_Zero  in  SHIFT_W  shift amount from ZeroDecode.
- ShiftEn_Zero  in  1  shift request from ZeroDecode.
- LevelDecodeDone  in  1  level decode complete.
- ZeroDecodeDone  in  1  zero decode complete.
- ShiftEn  out  1  to barrel shifter.
- NumShift  out  SHIFT_W  to barrel shifter.
- CoeffTokenDecodeEnable  out  1  enable to CoeffTokenDecode.
- LevelDecodeEnable  out  1  enable to LevelDecode.
- ZeroDecodeEnable  out  1  enable to ZeroDecode.
- BarrelShiftEn  out  1  shifter run enable.
- BlockDone  out  1  one-cycle pulse per completed block.
- MbDone  out  1  one-cycle pulse, coincident with BlockDone of the last block.
- BlockIdx  out  max(1,$clog2(BLOCKS_PER_MB))  index of the current block.
- Error  out  1  sticky watchdog error.

## Operation
States and transitions:
- IDLE: goes to WAIT_BS when Enable.
- WAIT_BS: goes to CT0 when BarrelShifterReady.
- CT0: always goes to CT1.
- CT1: goes to LEVEL, or takes the block-completion path when TotalCoeff==0.
- LEVEL: goes to ZERO when LevelDecodeDone.
- ZERO: takes the block-completion path when ZeroDecodeDone.
- ERR: holds until Abort.

Block completion:
- Completion event = (CT1 && TotalCoeff==0) || (ZERO && ZeroDecodeDone).
- On the event: BlockIdx increments. If BlockIdx==BLOCKS_PER_MB-1 it wraps to 0 and MbDone is asserted.
- Next state after the event is CT0 if Enable, else IDLE.

Watchdog:
- A counter clears on every state change.
- While in LEVEL or ZERO, reaching TIMEOUT cycles without the matching done sends the FSM to ERR and sets Error.

Abort:
- Abort in any state goes to IDLE on the next edge and clears BlockIdx, Error and the watchdog.
- Abort beats simultaneous done/timeout.
- Abort clears Error and BlockIdx, but BlockDone and MbDone are still the registered form of the previous cycle's completion event. If a completion event happened in the cycle before Abort, that pulse appears in the same cycle Abort is applied.

Shift mux (combinational from state):
- CT1: ShiftEn=1, NumShift=NumShift_CoeffToken.
- LEVEL: Level inputs.
- ZERO: Zero inputs.
- Any other state: both 0.

Other rules:
- An illegal state encoding recovers to IDLE.
- TotalCoeff values 17..31 are treated as non-zero; no range check.

## Timing
- Reset: state IDLE; every output 0; BlockIdx 0.
- Decoder enables are registered from state, so each is high one cycle after its state is entered:
  - CoeffTokenDecodeEnable from CT0.
  - LevelDecodeEnable from LEVEL.
  - ZeroDecodeEnable from ZERO.
- BarrelShiftEn is registered: 1 whenever the state is not IDLE and not ERR.
- BlockDone and MbDone are registered from the completion event, so they rise 1 cycle after it and last exactly 1 cycle.
- BlockIdx updates on the same edge BlockDone rises.
- Error rises on the edge entering ERR and stays high until the edge after Abort.
- Minimum block time:
  - 2 cycles (CT0, CT1) for an empty block.
  - 4 cycles when done arrives immediately.
- Back-to-back blocks run with no idle cycle while Enable is held.

## Structure
- Shared package cavlc_pkg holds:
  - the state enum typedef (IDLE, WAIT_BS, CT0, CT1, LEVEL, ZERO, ERR);
  - a shift-request struct {en, num[SHIFT_W-1:0]} used by all decoders.
- One natural sub-module: cavlc_watchdog. It is a loadable down-counter with clear/enable inputs and an expired output.

## Test plan
- Reset, then Enable=1, BarrelShifterReady=1, TotalCoeff=3, each done asserted 2 cycles after entering its state:
  - CoeffTokenDecodeEnable pulses once;
  - BlockDone pulses 1 cycle after the ZeroDecodeDone cycle;
  - BlockIdx goes 0→1.
- TotalCoeff=0 in CT1: LevelDecodeEnable and ZeroDecodeEnable stay 0, and BlockDone pulses 1 cycle after CT1.
- BLOCKS_PER_MB=4, four consecutive empty blocks: MbDone coincides with the 4th BlockDone, BlockIdx returns to 0, and there are no idle cycles between blocks.
- TIMEOUT=8, LevelDecodeDone held 0:
  - Error rises 8 cycles after entering LEVEL;
  - BarrelShiftEn drops;
  - Abort returns to IDLE with Error=0 one cycle later.
- Abort asserted in the same cycle as ZeroDecodeDone: the FSM goes to IDLE, BlockIdx=0 and BlockDone is not asserted.
- In LEVEL with ShiftEn_Level=1 and NumShift_Level=7: ShiftEn=1 and NumShift=7 in the same cycle. In IDLE, both are 0.
